// File: rtl/alu_sched.sv
// -----------------------------------------------------------------------------
// alu_sched -- two-requester round-robin scheduler for a shared external
// combinational ALU.
//
// One operation is in flight at a time. A granted request is latched into the
// alu_* drive registers (EXEC next cycle). At the end of EXEC the ALU output is
// captured into rsp_*. The response is then held (HOLD) until the consumer
// takes it. The scheduler forwards mode/opsel/cin untouched and does no
// arithmetic of its own.
//
// Valid/ready: a transfer happens in any cycle where valid and ready are both
// high at the rising edge of clk. Ready never depends on anything sampled after
// that edge. The producer must hold its payload stable while valid is high and
// ready is low, but may drop valid without penalty.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   reqN_valid / reqN_ready     request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b              operands
//   reqN_mode, reqN_opsel,
//   reqN_cin                    ALU control for requester N
//   alu_a, alu_b, alu_mode,
//   alu_opsel, alu_cin          registered drive to the external ALU
//   alu_result, alu_cout        ALU outputs (combinational from alu_*)
//   rsp_valid / rsp_ready       response handshake
//   rsp_id                      index of the requester that owns the response
//   rsp_result, rsp_cout        captured ALU outputs
//   rsp_zero                    (only with ALU_SCHED_ZERO_FLAG_EN) result == 0
//   o_dbg_state                 current FSM state (0 IDLE, 1 EXEC, 2 HOLD)
//
// Build option: define ALU_SCHED_ZERO_FLAG_EN to add the rsp_zero output.
// -----------------------------------------------------------------------------
module alu_sched #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_mode,
    input  logic [2:0]       req0_opsel,
    input  logic             req0_cin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_mode,
    input  logic [2:0]       req1_opsel,
    input  logic             req1_cin,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_mode,
    output logic [2:0]       alu_opsel,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
`ifdef ALU_SCHED_ZERO_FLAG_EN
    output logic             rsp_zero,
`endif
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_grant0;
    logic               w_grant1;
    logic               r_last_grant;
    logic [WIDTH-1:0]   r_alu_a;
    logic [WIDTH-1:0]   r_alu_b;
    logic               r_alu_mode;
    logic [2:0]         r_alu_opsel;
    logic               r_alu_cin;
    logic               r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_result;
    logic               r_rsp_cout;
`ifdef ALU_SCHED_ZERO_FLAG_EN
    logic               r_rsp_zero;
`endif

    // Next state and grant. Grants exist only in IDLE. On a tie the requester
    // that did not win last time is chosen.
    always_comb begin
        w_next_state = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant0 = req0_valid & (~req1_valid | r_last_grant);
                w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);
                if (w_grant0 | w_grant1) begin
                    w_next_state = S_EXEC;
                end
            end
            S_EXEC: w_next_state = S_HOLD;
            S_HOLD: begin
                if (rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Reset beats any handshake, so ready is masked while rst is high.
    assign req0_ready = w_grant0 & ~rst;
    assign req1_ready = w_grant1 & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_mode   <= 1'b0;
            r_alu_opsel  <= 3'd0;
            r_alu_cin    <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_cout   <= 1'b0;
`ifdef ALU_SCHED_ZERO_FLAG_EN
            r_rsp_zero   <= 1'b0;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_grant0) begin
                r_alu_a      <= req0_a;
                r_alu_b      <= req0_b;
                r_alu_mode   <= req0_mode;
                r_alu_opsel  <= req0_opsel;
                r_alu_cin    <= req0_cin;
                r_last_grant <= 1'b0;
                r_rsp_id     <= 1'b0;
            end else if (w_grant1) begin
                r_alu_a      <= req1_a;
                r_alu_b      <= req1_b;
                r_alu_mode   <= req1_mode;
                r_alu_opsel  <= req1_opsel;
                r_alu_cin    <= req1_cin;
                r_last_grant <= 1'b1;
                r_rsp_id     <= 1'b1;
            end
            // The ALU has had a full cycle to settle on the latched inputs.
            if (r_state == S_EXEC) begin
                r_rsp_result <= alu_result;
                r_rsp_cout   <= alu_cout;
`ifdef ALU_SCHED_ZERO_FLAG_EN
                r_rsp_zero   <= (alu_result == '0);
`endif
            end
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_mode    = r_alu_mode;
    assign alu_opsel   = r_alu_opsel;
    assign alu_cin     = r_alu_cin;
    assign rsp_valid   = (r_state == S_HOLD);
    assign rsp_id      = r_rsp_id;
    assign rsp_result  = r_rsp_result;
    assign rsp_cout    = r_rsp_cout;
`ifdef ALU_SCHED_ZERO_FLAG_EN
    assign rsp_zero    = r_rsp_zero;
`endif
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_sched.sv
// -----------------------------------------------------------------------------
// tb_alu_sched -- self-checking bench for alu_sched.
//
// A small behavioural ALU sits on the alu_* bus. A transaction-level model
// tracks the one outstanding operation: when it was granted, what its operands
// were, and what response it must produce. Each cycle, the model checks ready,
// rsp_valid timing, alu_* stability and response contents. Directed sequences
// cover the documented scenarios; a random phase follows.
// Define ALU_SCHED_ZERO_FLAG_EN to also cover rsp_zero.
// -----------------------------------------------------------------------------
module tb_alu_sched;
    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         req0_valid = 0, req1_valid = 0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic         req0_mode = 0, req1_mode = 0, req0_cin = 0, req1_cin = 0;
    logic [2:0]   req0_opsel = 0, req1_opsel = 0;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         alu_mode, alu_cin, alu_cout;
    logic [2:0]   alu_opsel;
    logic         rsp_valid, rsp_id, rsp_cout;
    logic         rsp_ready = 0;
    logic [W-1:0] rsp_result;
    logic [1:0]   o_dbg_state;
`ifdef ALU_SCHED_ZERO_FLAG_EN
    logic         rsp_zero;
`endif

    alu_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_mode(req0_mode), .req0_opsel(req0_opsel), .req0_cin(req0_cin),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_mode(req1_mode), .req1_opsel(req1_opsel), .req1_cin(req1_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode), .alu_opsel(alu_opsel), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_cout(rsp_cout),
`ifdef ALU_SCHED_ZERO_FLAG_EN
        .rsp_zero(rsp_zero),
`endif
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- external ALU ----------------
    function automatic logic [W:0] alu_fn(input logic mode, input logic [2:0] opsel,
                                          input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin);
        logic [W:0] r;
        if (!mode) begin
            case (opsel)
                3'd0:    r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                3'd1:    r = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cin};
                3'd2:    r = {1'b0, a} + 1;
                default: r = {1'b0, a ^ {W{opsel[0]}}};
            endcase
        end else begin
            case (opsel)
                3'd0:    r = {1'b0, a & b};
                3'd1:    r = {1'b0, a | b};
                3'd2:    r = {1'b0, a ^ b};
                3'd3:    r = {1'b0, ~a};
                default: r = {1'b1, b};
            endcase
        end
        return r;
    endfunction

    always_comb {alu_cout, alu_result} = alu_fn(alu_mode, alu_opsel, alu_a, alu_b, alu_cin);

    // ---------------- scoreboard / checking ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];        // expected rsp_result
    logic [2:0]   exp_meta_q[$];   // expected {zero, cout, id}

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: one outstanding operation at most.
    int           cyc = 0;
    bit           m_pend = 0;
    int           m_hs_cyc = 0;
    bit           m_last = 1;
    bit           m_after_rst = 0;
    logic [W-1:0] m_a, m_b;
    logic         m_mode, m_cin;
    logic [2:0]   m_opsel;

    task automatic model_check();
        bit         g0, g1, exp_valid;
        logic [W:0] r;
        exp_valid = m_pend && (cyc - m_hs_cyc >= 2);
        if (m_after_rst) begin
            check("rst_rsp_id", W'(rsp_id), 0);
            check("rst_rsp_result", rsp_result, 0);
            check("rst_rsp_cout", W'(rsp_cout), 0);
            check("rst_alu_a", alu_a, 0);
            check("rst_alu_b", alu_b, 0);
            check("rst_alu_ctl", W'({alu_mode, alu_opsel, alu_cin}), 0);
`ifdef ALU_SCHED_ZERO_FLAG_EN
            check("rst_rsp_zero", W'(rsp_zero), 0);
`endif
            m_after_rst = 0;
        end
        check("rsp_valid", W'(rsp_valid), W'(exp_valid));
        g0 = !m_pend && !rst && req0_valid && (!req1_valid || m_last);
        g1 = !m_pend && !rst && req1_valid && (!req0_valid || !m_last);
        check("req0_ready", W'(req0_ready), W'(g0));
        check("req1_ready", W'(req1_ready), W'(g1));
        if (m_pend && (cyc - m_hs_cyc >= 1)) begin
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_ctl", W'({alu_mode, alu_opsel, alu_cin}), W'({m_mode, m_opsel, m_cin}));
        end
        if (exp_valid && exp_q.size() > 0) begin
            check("rsp_result", rsp_result, exp_q[0]);
            check("rsp_id", W'(rsp_id), W'(exp_meta_q[0][0]));
            check("rsp_cout", W'(rsp_cout), W'(exp_meta_q[0][1]));
`ifdef ALU_SCHED_ZERO_FLAG_EN
            check("rsp_zero", W'(rsp_zero), W'(exp_meta_q[0][2]));
`endif
        end
        if (rst) begin
            m_pend = 0;
            m_last = 1;
            exp_q.delete();
            exp_meta_q.delete();
            m_after_rst = 1;
        end else begin
            if (exp_valid && rsp_ready) begin
                void'(exp_q.pop_front());
                void'(exp_meta_q.pop_front());
                m_pend = 0;
            end
            if (g0 || g1) begin
                m_a     = g1 ? req1_a : req0_a;
                m_b     = g1 ? req1_b : req0_b;
                m_mode  = g1 ? req1_mode : req0_mode;
                m_opsel = g1 ? req1_opsel : req0_opsel;
                m_cin   = g1 ? req1_cin : req0_cin;
                r = alu_fn(m_mode, m_opsel, m_a, m_b, m_cin);
                exp_q.push_back(r[W-1:0]);
                exp_meta_q.push_back({r[W-1:0] == '0, r[W], g1});
                m_pend   = 1;
                m_hs_cyc = cyc;
                m_last   = g1;
            end
        end
        cyc++;
    endtask

    // ---------------- driver tasks ----------------
    // One clock: check at the falling edge, return 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int n, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic mode, input logic [2:0] opsel, input logic cin);
        if (n == 0) begin
            req0_a = a; req0_b = b; req0_mode = mode; req0_opsel = opsel; req0_cin = cin;
        end else begin
            req1_a = a; req1_b = b; req1_mode = mode; req1_opsel = opsel; req1_cin = cin;
        end
    endtask

    task automatic drain();
        req0_valid = 0;
        req1_valid = 0;
        rsp_ready  = 1;
        repeat (4) tick();
        rsp_ready  = 0;
    endtask

    task automatic wait_rsp(input string tag);
        int k;
        k = 0;
        while (!rsp_valid && k < 8) begin
            tick();
            k++;
        end
        if (!rsp_valid) check({tag, "_timeout"}, 0, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        @(posedge clk);
        #1;
        tick();
        rst = 0;

        // Single request: add, response two cycles after the handshake.
        set_req(0, 32'h5555_5555, 32'hAAAA_AAAA, 1'b0, 3'd0, 1'b0);
        req0_valid = 1;
        tick();
        req0_valid = 0;
        check("lat_t1_valid", W'(rsp_valid), 0);
        tick();
        check("lat_t2_valid", W'(rsp_valid), 1);
        check("add_result", rsp_result, 32'hFFFF_FFFF);
        check("add_cout", W'(rsp_cout), 0);
        check("add_id", W'(rsp_id), 0);
        drain();

        // Tie after reset: req0, then req1, then req0 again.
        rst = 1;
        tick();
        rst = 0;
        set_req(0, 32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 3'd0, 1'b0);
        set_req(1, 32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 3'd1, 1'b0);
        req0_valid = 1;
        req1_valid = 1;
        rsp_ready  = 1;
        tick();
        wait_rsp("tie1");
        check("tie1_id", W'(rsp_id), 0);
        check("tie1_result", rsp_result, 32'h0000_0000);
        tick();
        tick();
        wait_rsp("tie2");
        check("tie2_id", W'(rsp_id), 1);
        check("tie2_result", rsp_result, 32'hFFFF_FFFF);
        tick();
        check("tie3_req0_ready", W'(req0_ready), 1);
        check("tie3_req1_ready", W'(req1_ready), 0);
        tick();
        drain();

        // Back-pressure: rsp_ready low for four HOLD cycles, accepted on the fifth.
        set_req(0, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 3'd1, 1'b1);
        req0_valid = 1;
        tick();
        req0_valid = 0;
        req1_valid = 1;
        tick();
        repeat (4) begin
            check("hold_state", W'(o_dbg_state), 2);
            tick();
        end
        req1_valid = 0;
        rsp_ready  = 1;
        tick();
        rsp_ready  = 0;
        check("hold_exit_state", W'(o_dbg_state), 0);
        check("hold_exit_valid", W'(rsp_valid), 0);
        drain();

        // Reset during EXEC abandons the operation.
        set_req(0, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 3'd0, 1'b0);
        req0_valid = 1;
        tick();
        req0_valid = 0;
        rst = 1;
        tick();
        rst = 0;
        check("abort_valid", W'(rsp_valid), 0);
        check("abort_result", rsp_result, 0);
        check("abort_alu_a", alu_a, 0);
        req0_valid = 1;
        req1_valid = 1;
        #1;
        check("abort_req0_first", W'(req0_ready), 1);
        tick();
        drain();

`ifdef ALU_SCHED_ZERO_FLAG_EN
        // Zero flag: AND gives zero, OR does not.
        set_req(0, 32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 3'd0, 1'b0);
        req0_valid = 1;
        tick();
        req0_valid = 0;
        wait_rsp("zf_and");
        check("zf_and", W'(rsp_zero), 1);
        drain();
        set_req(0, 32'h5555_5555, 32'hAAAA_AAAA, 1'b1, 3'd1, 1'b0);
        req0_valid = 1;
        tick();
        req0_valid = 0;
        wait_rsp("zf_or");
        check("zf_or", W'(rsp_zero), 0);
        drain();
`endif

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 2; n++) begin
                logic [W-1:0] a, b;
                a = $urandom();
                b = ($urandom_range(0, 3) == 0) ? a : $urandom();
                set_req(n, a, b, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                        1'($urandom_range(0, 1)));
            end
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            rsp_ready  = ($urandom_range(0, 1) == 1);
            rst        = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
